// File: rtl/nn_pkg.sv
// Shared constants, result codes and FSM encoding for the NN frame feeder.
package nn_pkg;

   localparam int unsigned N_PIX   = 784;
   localparam int unsigned IDX_W   = $clog2(N_PIX);
   localparam int unsigned CLASS_W = 4;
   localparam int unsigned ERR_W   = 2;
   localparam int unsigned FCNT_W  = 16;

   localparam logic [IDX_W-1:0]   IDX_LAST      = IDX_W'(N_PIX - 1);
   localparam logic [CLASS_W-1:0] CLASS_INVALID = 4'hF;

   localparam logic [ERR_W-1:0] ERR_OK      = 2'd0;
   localparam logic [ERR_W-1:0] ERR_LEN     = 2'd1;
   localparam logic [ERR_W-1:0] ERR_TIMEOUT = 2'd2;

   typedef enum logic [2:0] {
      StCollect,
      StDrain,
      StLaunch,
      StWaitAck,
      StWaitDone,
      StResult
   } feeder_state_e;

   // Unsigned threshold compare producing one feature bit.
   function automatic logic binarize(input logic [7:0] pix, input logic [7:0] thr);
      return (pix >= thr);
   endfunction

endpackage

// File: rtl/nn_timeout_ctr.sv
// Wait-phase cycle counter; flags expiry once the count reaches TIMEOUT-1.
module nn_timeout_ctr
   import nn_pkg::*;
#(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   logic [CNT_W-1:0] r_cnt;

   // Count wait cycles; clear takes priority so each launch starts from zero.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_clear) begin
         r_cnt <= '0;
      end else if (i_enable) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_expired = (r_cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/nn_frame_feeder.sv
// Collects a binarized pixel frame, launches the classifier and returns its verdict.
module nn_frame_feeder
   import nn_pkg::*;
#(
   parameter int unsigned THRESHOLD = 128,
   parameter int unsigned TIMEOUT   = 64
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_pix_valid,
   output logic               o_pix_ready,
   input  logic [7:0]         i_pix_data,
   input  logic               i_pix_last,
   output logic [N_PIX-1:0]   o_nn_features,
   output logic               o_nn_start,
   input  logic               i_nn_done,
   input  logic [CLASS_W-1:0] i_nn_prediction,
   output logic               o_res_valid,
   input  logic               i_res_ready,
   output logic [CLASS_W-1:0] o_res_class,
   output logic [ERR_W-1:0]   o_res_err,
   output logic [FCNT_W-1:0]  o_frame_cnt
);

   localparam logic [7:0] THR8 = 8'(THRESHOLD);

   feeder_state_e      r_state;
   logic [IDX_W-1:0]   r_idx;
   logic [N_PIX-1:0]   r_features;
   logic               r_nn_start;
   logic               r_res_valid;
   logic [CLASS_W-1:0] r_res_class;
   logic [ERR_W-1:0]   r_res_err;
   logic [FCNT_W-1:0]  r_frame_cnt;

   logic w_pix_ready;
   logic w_pix_xfer;
   logic w_in_wait;
   logic w_ctr_clear;
   logic w_expired;

   assign w_pix_ready = (r_state == StCollect) || (r_state == StDrain);
   assign w_pix_xfer  = i_pix_valid && w_pix_ready;
   assign w_in_wait   = (r_state == StWaitAck) || (r_state == StWaitDone);
   // The counter is zeroed during LAUNCH so the first wait cycle sees count 0.
   assign w_ctr_clear = (r_state == StLaunch);

   nn_timeout_ctr #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout_ctr (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_clear   (w_ctr_clear),
      .i_enable  (w_in_wait),
      .o_expired (w_expired)
   );

   // Frame FSM: packs pixels, sequences the start/done handshake and holds the result.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= StCollect;
         r_idx       <= '0;
         r_features  <= '0;
         r_nn_start  <= 1'b0;
         r_res_valid <= 1'b0;
         r_res_class <= '0;
         r_res_err   <= ERR_OK;
         r_frame_cnt <= '0;
      end else begin
         r_nn_start <= 1'b0;
         unique case (r_state)
            StCollect: begin
               if (w_pix_xfer) begin
                  r_features[r_idx] <= binarize(i_pix_data, THR8);
                  if (i_pix_last) begin
                     r_idx <= '0;
                     if (r_idx == IDX_LAST) begin
                        r_state    <= StLaunch;
                        r_nn_start <= 1'b1;
                     end else begin
                        // Short frame: report immediately, never launch.
                        r_state     <= StResult;
                        r_res_valid <= 1'b1;
                        r_res_err   <= ERR_LEN;
                        r_res_class <= CLASS_INVALID;
                     end
                  end else if (r_idx == IDX_LAST) begin
                     // Long frame: swallow the excess up to its last pixel.
                     r_idx       <= '0;
                     r_state     <= StDrain;
                     r_res_err   <= ERR_LEN;
                     r_res_class <= CLASS_INVALID;
                  end else begin
                     r_idx <= r_idx + 1'b1;
                  end
               end
            end
            StDrain: begin
               if (w_pix_xfer && i_pix_last) begin
                  r_state     <= StResult;
                  r_res_valid <= 1'b1;
                  r_res_err   <= ERR_LEN;
                  r_res_class <= CLASS_INVALID;
               end
            end
            StLaunch: begin
               r_state <= StWaitAck;
            end
            StWaitAck: begin
               // A done level left over from the previous run must drop first.
               if (!i_nn_done) begin
                  r_state <= StWaitDone;
               end else if (w_expired) begin
                  r_state     <= StResult;
                  r_res_valid <= 1'b1;
                  r_res_err   <= ERR_TIMEOUT;
                  r_res_class <= CLASS_INVALID;
               end
            end
            StWaitDone: begin
               // Done wins over a simultaneous timeout.
               if (i_nn_done) begin
                  r_state     <= StResult;
                  r_res_valid <= 1'b1;
                  r_res_err   <= ERR_OK;
                  r_res_class <= i_nn_prediction;
               end else if (w_expired) begin
                  r_state     <= StResult;
                  r_res_valid <= 1'b1;
                  r_res_err   <= ERR_TIMEOUT;
                  r_res_class <= CLASS_INVALID;
               end
            end
            StResult: begin
               if (r_res_valid && i_res_ready) begin
                  r_res_valid <= 1'b0;
                  r_frame_cnt <= r_frame_cnt + 1'b1;
                  r_state     <= StCollect;
               end
            end
            default: begin
               r_state <= StCollect;
            end
         endcase
      end
   end

   assign o_pix_ready   = w_pix_ready;
   assign o_nn_features = r_features;
   assign o_nn_start    = r_nn_start;
   assign o_res_valid   = r_res_valid;
   assign o_res_class   = r_res_class;
   assign o_res_err     = r_res_err;
   assign o_frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_nn_frame_feeder.sv
// Scoreboard bench for nn_frame_feeder with a behavioural network model.
module tb_nn_frame_feeder;
   import nn_pkg::*;

   logic               clk = 1'b0;
   logic               rst;
   logic               pix_valid;
   logic               pix_ready;
   logic [7:0]         pix_data;
   logic               pix_last;
   logic [N_PIX-1:0]   nn_features;
   logic               nn_start;
   logic               nn_done;
   logic [3:0]         nn_prediction;
   logic               res_valid;
   logic               res_ready;
   logic [3:0]         res_class;
   logic [1:0]         res_err;
   logic [15:0]        frame_cnt;

   always #5 clk = ~clk;

   nn_frame_feeder #(
      .THRESHOLD (128),
      .TIMEOUT   (64)
   ) dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .i_pix_valid     (pix_valid),
      .o_pix_ready     (pix_ready),
      .i_pix_data      (pix_data),
      .i_pix_last      (pix_last),
      .o_nn_features   (nn_features),
      .o_nn_start      (nn_start),
      .i_nn_done       (nn_done),
      .i_nn_prediction (nn_prediction),
      .o_res_valid     (res_valid),
      .i_res_ready     (res_ready),
      .o_res_class     (res_class),
      .o_res_err       (res_err),
      .o_frame_cnt     (frame_cnt)
   );

   typedef struct {
      logic [3:0]  cls;
      logic [1:0]  err;
      logic [15:0] cnt;
   } res_t;

   res_t             res_q[$];
   logic [N_PIX-1:0] feat_q[$];

   int checks = 0;
   int passes = 0;
   int cyc = 0;
   int n_starts = 0;
   int start_cyc = 0;
   int rv_cyc = 0;
   int n_res = 0;
   int net_mode = 0;
   logic [3:0] net_pred = 4'd0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h required %0h", name, act, exp);
   endtask

   task automatic check_feat(input string name, input logic [N_PIX-1:0] exp);
      checks++;
      if (nn_features === exp) passes++;
      else $display("FAIL %s: got %h required %h", name, nn_features, exp);
   endtask

   // Hand-written pixel patterns and the feature bits each must produce.
   function automatic logic [7:0] pat_val(input int pat, input int k);
      case (pat)
         0: return (k % 2 == 1) ? 8'hFF : 8'h00;
         1: case (k % 3)
               0: return 8'd127;
               1: return 8'd128;
               default: return 8'd200;
            endcase
         default: case (k % 4)
               0: return 8'h80;
               1: return 8'h7F;
               2: return 8'hFF;
               default: return 8'h01;
            endcase
      endcase
   endfunction

   function automatic logic pat_bit(input int pat, input int k);
      case (pat)
         0: return (k % 2 == 1);
         1: return (k % 3 != 0);
         default: return (k % 2 == 0);
      endcase
   endfunction

   task automatic push_full(input int pat);
      logic [N_PIX-1:0] e;
      e = '0;
      for (int k = 0; k < N_PIX; k++) e[k] = pat_bit(pat, k);
      feat_q.push_back(e);
   endtask

   task automatic push_res(input logic [3:0] cls, input logic [1:0] err);
      res_t r;
      r.cls = cls;
      r.err = err;
      r.cnt = 16'(n_res);
      res_q.push_back(r);
      n_res++;
   endtask

   // Called just after a rising edge; returns just after the transfer edge.
   task automatic send_pix(input logic [7:0] d, input logic last);
      int t;
      t = 0;
      pix_valid = 1'b1;
      pix_data  = d;
      pix_last  = last;
      @(negedge clk);
      while (pix_ready !== 1'b1 && t < 500) begin
         @(negedge clk);
         t++;
      end
      if (pix_ready !== 1'b1) check("pix_ready_timeout", {63'd0, pix_ready}, 64'd1);
      @(posedge clk);
      #1;
      pix_valid = 1'b0;
      pix_last  = 1'b0;
   endtask

   task automatic send_frame(input int pat, input int n, input int last_at);
      for (int k = 0; k < n; k++) send_pix(pat_val(pat, k), k == last_at);
   endtask

   task automatic wait_results(input string name);
      int t;
      t = 0;
      while (res_q.size() != 0 && t < 2000) begin
         @(negedge clk);
         t++;
      end
      if (res_q.size() != 0) check(name, 64'(res_q.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   // Network model: reacts to each launch according to net_mode.
   initial begin
      nn_done = 1'b0;
      nn_prediction = 4'd0;
      forever begin
         @(negedge clk);
         if (nn_start === 1'b1 && rst === 1'b0) begin
            case (net_mode)
               0: begin
                  @(posedge clk);
                  #1 nn_done = 1'b0;
                  repeat (4) @(posedge clk);
                  #1;
                  nn_prediction = net_pred;
                  nn_done = 1'b1;
               end
               1: begin
                  // Stale done with a decoy prediction, one low cycle, then the real one.
                  nn_prediction = 4'd3;
                  nn_done = 1'b1;
                  repeat (4) @(posedge clk);
                  #1 nn_done = 1'b0;
                  @(posedge clk);
                  #1;
                  nn_prediction = net_pred;
                  nn_done = 1'b1;
               end
               default: begin
                  @(posedge clk);
                  #1 nn_done = 1'b0;
               end
            endcase
         end
      end
   end

   // Monitor: checks features at each launch and each result handshake.
   initial begin
      logic prev_rv;
      logic [N_PIX-1:0] ef;
      res_t r;
      prev_rv = 1'b0;
      forever begin
         @(negedge clk);
         if (rst === 1'b1) begin
            prev_rv = 1'b0;
         end else begin
            if (nn_start === 1'b1) begin
               n_starts++;
               start_cyc = cyc;
               if (feat_q.size() == 0) begin
                  checks++;
                  $display("FAIL unexpected_start: got nn_start=1 required 0");
               end else begin
                  ef = feat_q.pop_front();
                  check_feat("nn_features", ef);
               end
            end
            if (res_valid === 1'b1 && !prev_rv) rv_cyc = cyc;
            prev_rv = res_valid;
            if (res_valid === 1'b1 && res_ready === 1'b1) begin
               if (res_q.size() == 0) begin
                  checks++;
                  $display("FAIL unexpected_result: got class %0h err %0h required none",
                           res_class, res_err);
               end else begin
                  r = res_q.pop_front();
                  check("res_class", 64'(res_class), 64'(r.cls));
                  check("res_err", 64'(res_err), 64'(r.err));
                  check("frame_cnt_pre", 64'(frame_cnt), 64'(r.cnt));
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish required finish before 500us");
      $fatal(1, "watchdog");
   end

   initial begin
      int s;
      int t;
      rst = 1'b1;
      pix_valid = 1'b0;
      pix_data = 8'd0;
      pix_last = 1'b0;
      res_ready = 1'b1;

      @(posedge clk);
      @(negedge clk);
      check("rst_pix_ready", 64'(pix_ready), 64'd1);
      check("rst_res_valid", 64'(res_valid), 64'd0);
      check("rst_nn_start", 64'(nn_start), 64'd0);
      check("rst_res_class", 64'(res_class), 64'd0);
      check("rst_res_err", 64'(res_err), 64'd0);
      check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
      check_feat("rst_features", '0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Alternating black/white frame, prediction 7.
      net_mode = 0;
      net_pred = 4'd7;
      push_full(0);
      push_res(4'd7, ERR_OK);
      send_frame(0, N_PIX, N_PIX - 1);
      wait_results("t1_result_timeout");
      check("t1_start_count", 64'(n_starts), 64'd1);
      check("t1_done_to_valid", 64'(rv_cyc - start_cyc), 64'd6);
      check("t1_frame_cnt", 64'(frame_cnt), 64'd1);

      // Threshold boundary 127/128.
      net_pred = 4'd2;
      push_full(1);
      push_res(4'd2, ERR_OK);
      send_frame(1, N_PIX, N_PIX - 1);
      wait_results("t2_result_timeout");

      // Short frame, then a normal frame.
      s = n_starts;
      push_res(CLASS_INVALID, ERR_LEN);
      send_frame(2, 101, 100);
      wait_results("t3s_result_timeout");
      check("t3_short_no_start", 64'(n_starts), 64'(s));
      net_pred = 4'd4;
      push_full(2);
      push_res(4'd4, ERR_OK);
      send_frame(2, N_PIX, N_PIX - 1);
      wait_results("t3_result_timeout");

      // Long frame drained.
      s = n_starts;
      push_res(CLASS_INVALID, ERR_LEN);
      send_frame(0, 790, 789);
      wait_results("t4_result_timeout");
      check("t4_long_no_start", 64'(n_starts), 64'(s));

      // Stale done high from previous run.
      net_mode = 1;
      net_pred = 4'd9;
      push_full(1);
      push_res(4'd9, ERR_OK);
      send_frame(1, N_PIX, N_PIX - 1);
      wait_results("t5a_result_timeout");
      check("t5a_done_to_valid", 64'(rv_cyc - start_cyc), 64'd6);

      // Done stuck low: timeout.
      net_mode = 2;
      push_full(0);
      push_res(CLASS_INVALID, ERR_TIMEOUT);
      send_frame(0, N_PIX, N_PIX - 1);
      wait_results("t5b_result_timeout");
      check("t5b_timeout_latency", 64'(rv_cyc - start_cyc), 64'd65);

      // Consumer back-pressure with pixels waiting.
      net_mode = 0;
      net_pred = 4'd5;
      res_ready = 1'b0;
      push_full(2);
      push_res(4'd5, ERR_OK);
      send_frame(2, N_PIX, N_PIX - 1);
      pix_valid = 1'b1;
      pix_data = 8'hFF;
      pix_last = 1'b0;
      t = 0;
      @(negedge clk);
      while (res_valid !== 1'b1 && t < 200) begin
         @(negedge clk);
         t++;
      end
      for (int i = 0; i < 20; i++) begin
         check("t6_hold_valid", 64'(res_valid), 64'd1);
         check("t6_hold_class", 64'(res_class), 64'd5);
         check("t6_hold_pix_ready", 64'(pix_ready), 64'd0);
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      pix_valid = 1'b0;
      res_ready = 1'b1;
      wait_results("t6_result_timeout");

      // Reset in the middle of WAIT_DONE discards the frame.
      net_mode = 2;
      push_full(1);
      send_frame(1, N_PIX, N_PIX - 1);
      repeat (10) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("mid_rst_pix_ready", 64'(pix_ready), 64'd1);
      check("mid_rst_res_valid", 64'(res_valid), 64'd0);
      check("mid_rst_nn_start", 64'(nn_start), 64'd0);
      check("mid_rst_res_class", 64'(res_class), 64'd0);
      check("mid_rst_res_err", 64'(res_err), 64'd0);
      check("mid_rst_frame_cnt", 64'(frame_cnt), 64'd0);
      check_feat("mid_rst_features", '0);
      @(posedge clk);
      #1 rst = 1'b0;
      n_res = 0;

      // Recovery frame after reset.
      net_mode = 0;
      net_pred = 4'd1;
      push_full(0);
      push_res(4'd1, ERR_OK);
      send_frame(0, N_PIX, N_PIX - 1);
      wait_results("t7_result_timeout");
      check("t7_frame_cnt", 64'(frame_cnt), 64'd1);

      repeat (5) @(posedge clk);
      check("end_res_q_empty", 64'(res_q.size()), 64'd0);
      check("end_feat_q_empty", 64'(feat_q.size()), 64'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
